button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 8: consecutive stable synchronized samples needed to accept a level change; legal range >= 2.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 32: cycles in PRESSED before a long-press event; legal range >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous, bouncy push-button level; 1 = pressed.
REQ-006 SHALL have port btn_level  output  1  debounced level; 1 in PRESSED and RELEASE_WAIT.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-009 SHALL have port long_press_pulse  output  1  one-cycle strobe when a press is held LONG_PRESS_CYCLES.
REQ-010 SHALL have port press_count  output  8  count of accepted presses, modulo 256.

Function
REQ-011 btn_in SHALL pass through a two-flop synchronizer; only its output (btn_s) feeds the FSM.
REQ-012 FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: btn_s=1 -> PRESS_WAIT, debounce counter = 1; otherwise stay.
REQ-014 PRESS_WAIT: btn_s=0 -> IDLE, counter cleared; btn_s=1 with counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-015 Entry to PRESSED SHALL register press_pulse=1 for exactly one cycle, increment press_count (255 wraps to 0) and clear the hold counter.
REQ-016 Latency: with btn_in stable high, press_pulse SHALL be high in the cycle that begins DEBOUNCE_CYCLES+1 rising edges after the edge that first samples btn_in=1.
REQ-017 PRESSED: btn_s=0 -> RELEASE_WAIT, debounce counter = 1; otherwise the hold counter increments, saturating at LONG_PRESS_CYCLES.
REQ-018 long_press_pulse SHALL be high for one cycle when the hold counter reaches LONG_PRESS_CYCLES, and at most once per accepted press.
REQ-019 If btn_s=0 in the same cycle the hold counter would reach LONG_PRESS_CYCLES, the transition to RELEASE_WAIT SHALL win and no long_press_pulse is generated that cycle.
REQ-020 RELEASE_WAIT: btn_s=1 -> PRESSED with no press_pulse and no press_count change, hold counter preserved; btn_s=0 with counter = DEBOUNCE_CYCLES-1 -> IDLE with release_pulse=1 for one cycle; otherwise counter increments.
REQ-021 The hold counter SHALL be frozen in RELEASE_WAIT.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse, no btn_level change and no count change.
REQ-023 All outputs SHALL be registered; at most one of the three pulses is high in any cycle.

Reset
REQ-024 rst=1 at a rising edge SHALL force state IDLE, clear all counters and synchronizer flops, and drive every output to 0, regardless of btn_in.
REQ-025 Reset mid-press SHALL abort the press with no release_pulse; if btn_in stays high after reset, a new press SHALL be debounced and reported per REQ-016.

Structure
REQ-026 Package button_pkg SHALL hold the state enum typedef (btn_state_t) and default constants DEBOUNCE_CYCLES_DEF=8, LONG_PRESS_CYCLES_DEF=32 and PRESS_COUNT_W=8.
REQ-027 Counter widths SHALL be $clog2 of their maximum value + 1.
REQ-028 The synchronizer SHALL be the sub-module sync_2ff (clk, rst, d, q), reusable for other asynchronous inputs.

Verification
REQ-029 DEBOUNCE_CYCLES=4; rst high for 2 cycles, then btn_in=1 held -> press_pulse high exactly 5 edges after the first sampling edge; press_count=1; btn_level=1.
REQ-030 btn_in bursts 1,0,1,1,0 (single cycles), then low -> no pulses, btn_level=0, press_count=0.
REQ-031 LONG_PRESS_CYCLES=10; hold 40 cycles -> exactly one long_press_pulse, 10 cycles after press_pulse; release -> one release_pulse, 4+1 edges after btn_in falls.
REQ-032 While pressed, btn_in low for 2 cycles then high -> no release_pulse, no second press_pulse, press_count unchanged.
REQ-033 256 clean presses -> press_count wraps to 0; on the 257th press it reads 1.
REQ-034 rst asserted mid-press with btn_in held high -> all outputs 0 during reset; after release a new press_pulse per REQ-016 with press_count=1.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF   = 8;
  localparam int LONG_PRESS_CYCLES_DEF = 32;
  localparam int PRESS_COUNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button and reports press, release and long-press events.
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_in,
  output logic                     btn_level,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic                     long_press_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic btn_s;

  btn_state_t               state_q, state_d;
  logic [DB_W-1:0]          db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [PRESS_COUNT_W-1:0] count_q, count_d;
  logic                     level_q, level_d;
  logic                     press_q, press_d;
  logic                     rel_q, rel_d;
  logic                     long_q, long_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    hold_d   = hold_q;
    count_d  = count_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = DB_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
          hold_d   = '0;
          press_d  = 1'b1;
          count_d  = count_q + PRESS_COUNT_W'(1);
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        // A falling sample takes priority over the hold counter reaching its limit.
        if (!btn_s) begin
          state_d  = ST_RELEASE_WAIT;
          db_cnt_d = DB_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_W'(1);
          long_d = (hold_q == HOLD_LAST);
        end
      end
      ST_RELEASE_WAIT: begin
        // Bounce back to PRESSED keeps the hold count so a long press still fires once.
        if (btn_s) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
          rel_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      db_cnt_q <= '0;
      hold_q   <= '0;
      count_q  <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      count_q  <= count_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = rel_q;
  assign long_press_pulse = long_q;
  assign press_count      = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scenario bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

  localparam int DB = 4;
  localparam int LP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level, press_pulse, release_pulse, long_press_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int failures = 0;

  button_debouncer #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
    .clk              (clk),
    .rst              (rst),
    .btn_in           (btn_in),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .press_count      (press_count)
  );

  always #5 clk = ~clk;

  // Reference: raw input delayed two samples; a level flips once DB consecutive
  // samples disagree with it; hold time accrues only on agreeing samples after
  // an unbroken pressed run.
  logic m_s1 = 0, m_s2 = 0, m_level = 0, m_press = 0, m_rel = 0, m_long = 0;
  int   m_run = 0, m_held = 0, m_count = 0;

  always @(posedge clk) begin
    logic samp;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_held = 0; m_count = 0;
      m_press = 0; m_rel = 0; m_long = 0;
    end else begin
      samp = m_s2; m_s2 = m_s1; m_s1 = btn_in;
      m_press = 0; m_rel = 0; m_long = 0;
      if (samp != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = samp;
          m_run = 0;
          if (samp) begin
            m_press = 1; m_count = (m_count + 1) % 256; m_held = 0;
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        if (m_level && m_run == 0 && m_held < LP) begin
          m_held++;
          if (m_held == LP) m_long = 1;
        end
        m_run = 0;
      end
    end
  end

  wire [11:0] obs   = {btn_level, press_pulse, release_pulse, long_press_pulse, press_count};
  wire [11:0] exp_o = {m_level, m_press, m_rel, m_long, 8'(m_count)};

  task automatic step(input logic b);
    @(negedge clk);
    btn_in = b;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    btn_in = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)));
      checks++;
      if (obs !== 12'h000) begin
        failures++; $display("FAIL reset_outputs obs=%h exp=000", obs);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_press_latency;
    do_reset(2);
    btn_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      checks++;
      if (obs !== exp_o) begin
        failures++; $display("FAIL latency_model i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
      checks++;
      if (press_pulse !== (i == 6)) begin
        failures++; $display("FAIL latency_pulse i=%0d got=%b want=%b", i, press_pulse, i == 6);
      end
    end
    checks++;
    if (press_count !== 8'd1 || btn_level !== 1'b1) begin
      failures++; $display("FAIL latency_state count=%0d level=%b want 1/1", press_count, btn_level);
    end
  endtask

  task automatic test_glitch;
    logic [4:0] pat;
    pat = 5'b01101;
    do_reset(2);
    for (int i = 0; i < 17; i++) begin
      step(i < 5 ? pat[i] : 1'b0);
      checks++;
      if (obs !== exp_o || obs !== 12'h000) begin
        failures++; $display("FAIL glitch i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_long_press;
    int p = -1, q = -1, lc = 0, rc = 0;
    do_reset(2);
    btn_in = 1'b1;
    for (int i = 1; i <= 46; i++) begin
      step(1'b1);
      checks++;
      if (obs !== exp_o) begin
        failures++; $display("FAIL long_model i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
      if (press_pulse === 1'b1) p = i;
      if (long_press_pulse === 1'b1) begin lc++; q = i; end
    end
    checks++;
    if (lc != 1 || q - p != LP) begin
      failures++; $display("FAIL long_count got=%0d dist=%0d want 1/%0d", lc, q - p, LP);
    end
    btn_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      checks++;
      if (obs !== exp_o) begin
        failures++; $display("FAIL release_model i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
      checks++;
      if (release_pulse !== (i == 6)) begin
        failures++; $display("FAIL release_latency i=%0d got=%b want=%b", i, release_pulse, i == 6);
      end
      if (release_pulse === 1'b1) rc++;
    end
    checks++;
    if (rc != 1 || btn_level !== 1'b0) begin
      failures++; $display("FAIL release_once got=%0d level=%b want 1/0", rc, btn_level);
    end
  endtask

  task automatic test_short_release;
    do_reset(2);
    btn_in = 1'b1;
    repeat (8) step(1'b1);
    for (int i = 0; i < 14; i++) begin
      step((i == 0 || i == 1) ? 1'b0 : 1'b1);
      checks++;
      if (obs !== exp_o || release_pulse !== 1'b0 || press_pulse !== 1'b0 ||
          press_count !== 8'd1 || btn_level !== 1'b1) begin
        failures++; $display("FAIL short_release i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
    end
  endtask

  task automatic test_wrap;
    do_reset(2);
    for (int k = 1; k <= 257; k++) begin
      repeat (7) step(1'b1);
      repeat (7) step(1'b0);
      checks++;
      if (obs !== exp_o) begin
        failures++; $display("FAIL wrap_model k=%0d obs=%h exp=%h", k, obs, exp_o);
      end
      if (k == 256 || k == 257) begin
        checks++;
        if (press_count !== 8'(k)) begin
          failures++; $display("FAIL wrap_count k=%0d got=%0d want=%0d", k, press_count, 8'(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_press;
    do_reset(2);
    btn_in = 1'b1;
    repeat (10) step(1'b1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      checks++;
      if (obs !== 12'h000) begin
        failures++; $display("FAIL midrst_zero i=%0d obs=%h exp=000", i, obs);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      checks++;
      if (obs !== exp_o || press_pulse !== (i == 6) || release_pulse !== 1'b0) begin
        failures++; $display("FAIL midrst_press i=%0d obs=%h exp=%h", i, obs, exp_o);
      end
    end
    checks++;
    if (press_count !== 8'd1) begin
      failures++; $display("FAIL midrst_count got=%0d want=1", press_count);
    end
  endtask

  task automatic test_random;
    do_reset(2);
    for (int s = 0; s < 120; s++) begin
      logic v;
      int len;
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) begin
        step(v);
        checks++;
        if (obs !== exp_o) begin
          failures++; $display("FAIL random s=%0d obs=%h exp=%h", s, obs, exp_o);
        end
        checks++;
        if (int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse) > 1) begin
          failures++; $display("FAIL pulse_onehot got=%b%b%b want at most one",
                               press_pulse, release_pulse, long_press_pulse);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_long_press();
    test_short_release();
    test_wrap();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
